// File: rtl/circuit_unit_pkg.sv
// Shared definitions for the circuit_unit two-input programmable Boolean block.
// Holds the truth-table width and named tables for common two-input functions.
// Table bit index is {x1,x2}, so bit 3 is the x1=1,x2=1 entry.
package circuit_unit_pkg;

  localparam int TT_W = 4;

  localparam logic [TT_W-1:0] TT_AND  = 4'b1000;
  localparam logic [TT_W-1:0] TT_OR   = 4'b1110;
  localparam logic [TT_W-1:0] TT_XOR  = 4'b0110;
  localparam logic [TT_W-1:0] TT_NAND = 4'b0111;
  localparam logic [TT_W-1:0] TT_NOR  = 4'b0001;
  localparam logic [TT_W-1:0] TT_XNOR = 4'b1001;

endpackage

// File: rtl/circuit_edge_cnt.sv
// Saturating event counter with asynchronous active-high reset.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset, clears cnt
//   rise - count enable; one increment per clock edge where it is high
//   cnt  - current count, holds at all-ones instead of wrapping
module circuit_edge_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rise,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (rise && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/circuit_unit.sv
// Two-input programmable Boolean function block.
// z is a purely combinational lookup tt[{x1,x2}]; the table is loadable at run
// time and resets to TT_DEFAULT. A registered copy of z and a saturating count
// of its 0->1 transitions are provided for downstream synchronous logic.
// Ports:
//   clk      - rising-edge clock
//   rst      - asynchronous active-high reset
//   x1, x2   - function inputs (x1 is the table index MSB)
//   tt_we    - table write enable, sampled on clk rising edge
//   tt_wdata - new table contents
//   tt       - current table readback
//   z        - combinational result
//   z_q      - z registered on clk
//   rise_cnt - saturating count of z_q rising transitions
module circuit_unit
  import circuit_unit_pkg::*;
#(
  parameter logic [TT_W-1:0] TT_DEFAULT = TT_XOR,
  parameter int              CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x1,
  input  logic             x2,
  input  logic             tt_we,
  input  logic [TT_W-1:0]  tt_wdata,
  output logic [TT_W-1:0]  tt,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] rise_cnt
);

  logic rise;

  // Table lookup has no clock in its path; during reset tt holds TT_DEFAULT,
  // so z stays meaningful.
  assign z = tt[{x1, x2}];

  // z_q is about to go 0->1 on this edge.
  assign rise = z & ~z_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; z_q therefore captures z from the old table on
  // the same edge that loads a new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tt  <= TT_DEFAULT;
      z_q <= 1'b0;
    end else begin
      if (tt_we) begin
        tt <= tt_wdata;
      end
      z_q <= z;
    end
  end

  circuit_edge_cnt #(
    .CNT_W (CNT_W)
  ) u_edge_cnt (
    .clk  (clk),
    .rst  (rst),
    .rise (rise),
    .cnt  (rise_cnt)
  );

endmodule

// File: tb/tb_circuit_unit.sv
// Self-checking bench for circuit_unit: a reference model predicts z_q,
// rise_cnt, tt and z for each clocked step and queues the expectation; it is
// popped and compared once the edge has occurred. A second instance with a
// 2-bit counter exercises saturation.
module tb_circuit_unit;
  import circuit_unit_pkg::*;

  typedef struct {
    logic        zq;
    logic [15:0] cnt;
    logic [3:0]  tt;
    logic        z_post;
  } exp_t;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst;
  logic        x1, x2, tt_we;
  logic [3:0]  tt_wdata;
  logic [3:0]  tt;
  logic        z, z_q;
  logic [15:0] rise_cnt;

  logic        s_x1, s_x2;
  logic [3:0]  s_tt;
  logic        s_z, s_z_q;
  logic [1:0]  s_cnt;

  int total = 0;
  int bad = 0;

  exp_t sb[$];
  int   sat_q[$];

  // reference model state
  logic [3:0]  m_tt;
  logic        m_zq;
  logic [15:0] m_cnt;

  circuit_unit dut (
    .clk      (clk),
    .rst      (rst),
    .x1       (x1),
    .x2       (x2),
    .tt_we    (tt_we),
    .tt_wdata (tt_wdata),
    .tt       (tt),
    .z        (z),
    .z_q      (z_q),
    .rise_cnt (rise_cnt)
  );

  circuit_unit #(.TT_DEFAULT(TT_XOR), .CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .x1       (s_x1),
    .x2       (s_x2),
    .tt_we    (1'b0),
    .tt_wdata (4'b0000),
    .tt       (s_tt),
    .z        (s_z),
    .z_q      (s_z_q),
    .rise_cnt (s_cnt)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    m_tt  = TT_XOR;
    m_zq  = 1'b0;
    m_cnt = '0;
    sb.delete();
  endtask

  // One clocked step, starting just after a rising edge.
  task automatic cycle(input logic a, input logic b, input logic we,
                       input logic [3:0] wd);
    exp_t e;
    logic zpre;
    x1 = a; x2 = b; tt_we = we; tt_wdata = wd;
    zpre = m_tt[{a, b}];
    if (zpre && !m_zq && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'd1;
    m_zq = zpre;
    if (we) m_tt = wd;
    e.zq = m_zq; e.cnt = m_cnt; e.tt = m_tt; e.z_post = m_tt[{a, b}];
    sb.push_back(e);
    @(negedge clk); #3;
    total++;
    if (z !== zpre) begin bad++; $display("FAIL z_pre x=%b%b: got %b want %b", a, b, z, zpre); end
    @(posedge clk); #1;
    tt_we = 1'b0;
    e = sb.pop_front();
    total++;
    if (z_q !== e.zq) begin bad++; $display("FAIL z_q x=%b%b: got %b want %b", a, b, z_q, e.zq); end
    total++;
    if (rise_cnt !== e.cnt) begin bad++; $display("FAIL rise_cnt: got %0d want %0d", rise_cnt, e.cnt); end
    total++;
    if (tt !== e.tt) begin bad++; $display("FAIL tt: got %b want %b", tt, e.tt); end
    total++;
    if (z !== e.z_post) begin bad++; $display("FAIL z_post x=%b%b: got %b want %b", a, b, z, e.z_post); end
  endtask

  task automatic test_reset();
    rst = 1'b1; x1 = 1'b0; x2 = 1'b0; tt_we = 1'b0; tt_wdata = 4'h0;
    s_x1 = 1'b0; s_x2 = 1'b0;
    model_reset();
    #2;
    total++;
    if (tt !== TT_XOR) begin bad++; $display("FAIL reset_tt: got %b want %b", tt, TT_XOR); end
    total++;
    if (z_q !== 1'b0) begin bad++; $display("FAIL reset_z_q: got %b want 0", z_q); end
    total++;
    if (rise_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", rise_cnt); end
    total++;
    if (z !== 1'b0) begin bad++; $display("FAIL reset_z: got %b want 0", z); end
    rst = 1'b0;
    #2;
  endtask

  task automatic test_comb_xor();
    logic [3:0] want;
    want = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      x1 = i[1]; x2 = i[0];
      #10;
      total++;
      if (z !== want[i]) begin bad++; $display("FAIL comb_xor x=%0d: got %b want %b", i, z, want[i]); end
    end
    x1 = 1'b0; x2 = 1'b0;
  endtask

  task automatic sweep_const(input logic [3:0] want, input logic [3:0] table_want);
    for (int i = 0; i < 4; i++) begin
      cycle(i[1], i[0], 1'b0, 4'h0);
      total++;
      if (z !== want[i]) begin bad++; $display("FAIL sweep x=%0d: got %b want %b", i, z, want[i]); end
      total++;
      if (tt !== table_want) begin bad++; $display("FAIL sweep_tt: got %b want %b", tt, table_want); end
    end
  endtask

  task automatic test_table_reload();
    cycle(1'b0, 1'b0, 1'b1, 4'b1000);
    sweep_const(4'b1000, 4'b1000);
    cycle(1'b0, 1'b0, 1'b1, 4'b1110);
    sweep_const(4'b1110, 4'b1110);
  endtask

  task automatic test_async_reset();
    cycle(1'b0, 1'b0, 1'b1, 4'b0001);
    cycle(1'b0, 1'b0, 1'b0, 4'h0);  // NOR(0,0)=1 so z_q is high going into reset
    @(negedge clk); #1;
    rst = 1'b1; x1 = 1'b0; x2 = 1'b1;
    #1;
    total++;
    if (tt !== 4'b0110) begin bad++; $display("FAIL arst_tt: got %b want 0110", tt); end
    total++;
    if (z_q !== 1'b0) begin bad++; $display("FAIL arst_z_q: got %b want 0", z_q); end
    total++;
    if (rise_cnt !== 16'd0) begin bad++; $display("FAIL arst_cnt: got %0d want 0", rise_cnt); end
    total++;
    if (z !== 1'b1) begin bad++; $display("FAIL arst_z: got %b want 1", z); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; x1 = 1'b0; x2 = 1'b0;
    model_reset();
    @(posedge clk); #1;
    total++;
    if (z_q !== 1'b0 || rise_cnt !== 16'd0) begin
      bad++; $display("FAIL post_rst_edge: got z_q=%b cnt=%0d want z_q=0 cnt=0", z_q, rise_cnt);
    end
  endtask

  task automatic test_registered();
    cycle(1'b0, 1'b0, 1'b0, 4'h0);
    cycle(1'b0, 1'b1, 1'b0, 4'h0);
    cycle(1'b0, 1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 1'b0, 4'h0);
    cycle(1'b1, 1'b1, 1'b0, 4'h0);
    total++;
    if (rise_cnt !== 16'd2) begin bad++; $display("FAIL reg_final_cnt: got %0d want 2", rise_cnt); end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1'b1, 1'b1, 4'b1001);  // z checked 0 before, 1 after, inside cycle
    total++;
    if (z !== 1'b1) begin bad++; $display("FAIL same_cycle_z: got %b want 1", z); end
    cycle(1'b1, 1'b1, 1'b0, 4'h0);
    total++;
    if (z_q !== 1'b1) begin bad++; $display("FAIL same_cycle_z_q: got %b want 1", z_q); end
  endtask

  task automatic test_saturation();
    int rises;
    rises = 0;
    for (int i = 0; i < 5; i++) begin
      rises++;
      sat_q.push_back((rises > 3) ? 3 : rises);
      s_x1 = 1'b0; s_x2 = 1'b1;
      @(posedge clk); #1;
      s_x1 = 1'b0; s_x2 = 1'b0;
      @(posedge clk); #1;
      begin
        int exp_cnt;
        exp_cnt = sat_q.pop_front();
        total++;
        if (s_cnt !== 2'(exp_cnt)) begin
          bad++; $display("FAIL sat_cnt step %0d: got %0d want %0d", i, s_cnt, exp_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_comb_xor();
    clk_run = 1'b1;
    @(posedge clk); #1;
    test_table_reload();
    test_async_reset();
    test_registered();
    test_back_to_back();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
